adc_spi_model: RTL and testbench

Parametrised behavioural/synthesizable model of a multi-channel SPI A/D converter for bench and FPGA bring-up use. It is the generalised successor of the fixed 8-channel, 12-bit ADC model. Channel count, sample width, sample-set depth and sample-set advance policy are all configurable. It contains its own SPI slave (no separate SPI submodule) and sits on the board-level SPI bus opposite the A2D interface master.

---
 rtl/adc_spi_model_if.sv | 22 ++
 rtl/adc_spi_model.sv | 145 ++++++++++++++
 tb/tb_adc_spi_model.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_model_if.sv
// SPI bus between the board-level A2D interface master and the ADC model.
// The master drives select, clock and command data; the ADC drives MISO.
interface adc_spi_model_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output MISO
    );
endinterface

// File: rtl/adc_spi_model.sv
// adc_spi_model: multi-channel SPI A/D converter model with built-in SPI slave.
// Each 16-bit frame shifts in a command and shifts out the sample selected by
// the previous frame's command (pipelined response). The sample-set pointer
// advances at valid frame ends according to ADV_MODE.
// Samples are the synthetic (ptr*NUM_CH + ch) pattern.
module adc_spi_model #(
    parameter int NUM_CH   = 8,
    parameter int DATA_W   = 12,
    parameter int DEPTH    = 8192,
    parameter int ADV_MODE = 1,
    localparam int CH_W    = $clog2(NUM_CH),
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    adc_spi_model_if.slave     spi,
    output logic               rdy,
    output logic [15:0]        cmd,
    output logic [PTR_W-1:0]   ptr
);

    localparam int IDX_W = PTR_W + CH_W;

    logic [2:0]        ss_sync_q, ss_sync_d;
    logic [2:0]        sclk_sync_q, sclk_sync_d;
    logic [1:0]        mosi_sync_q, mosi_sync_d;

    logic              active_q, active_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [15:0]       shift_tx_q, shift_tx_d;
    logic [15:0]       shift_rx_q, shift_rx_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [15:0]       cmd_q, cmd_d;
    logic              rdy_q, rdy_d;

    logic              ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [CH_W-1:0]   new_chan;
    logic              chan_valid;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] sample;
    logic              advance;

    // Synchroniser shift chains for the asynchronous bus inputs.
    always_comb begin
        ss_sync_d   = {ss_sync_q[1:0], spi.SS_n};
        sclk_sync_d = {sclk_sync_q[1:0], spi.SCLK};
        mosi_sync_d = {mosi_sync_q[0], spi.MOSI};
    end

    // Synchronisers are left out of reset so that a bus held low across rst
    // does not look like a fresh SS_n fall once rst is released.
    always_ff @(posedge clk) begin
        ss_sync_q   <= ss_sync_d;
        sclk_sync_q <= sclk_sync_d;
        mosi_sync_q <= mosi_sync_d;
    end

    assign ss_fall   =  ss_sync_q[2]   & ~ss_sync_q[1];
    assign ss_rise   = ~ss_sync_q[2]   &  ss_sync_q[1];
    assign sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];
    assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];

    // Sample lookup from the current set pointer and channel.
    assign chan_valid = ({1'b0, chan_q} < (CH_W + 1)'(NUM_CH));
    assign idx        = IDX_W'(ptr_q) * IDX_W'(NUM_CH) + IDX_W'(chan_q);

    // Synthetic sample: linear index truncated to DATA_W.
    always_comb begin
        sample = '0;
        if (chan_valid) sample = DATA_W'(idx);
    end

    // Advance decision; mode 2 looks at the channel this frame writes.
    assign new_chan = shift_rx_q[11 +: CH_W];
    always_comb begin
        case (ADV_MODE)
            1:       advance = 1'b1;
            2:       advance = (new_chan == CH_W'(NUM_CH - 1));
            default: advance = 1'b0;
        endcase
    end

    // Frame engine: load on select, shift on SCLK edges, commit on deselect.
    always_comb begin
        active_d   = active_q;
        chan_d     = chan_q;
        ptr_d      = ptr_q;
        shift_tx_d = shift_tx_q;
        shift_rx_d = shift_rx_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_d      = cmd_q;
        rdy_d      = 1'b0;
        if (ss_fall) begin
            active_d   = 1'b1;
            bit_cnt_d  = '0;
            shift_tx_d = 16'(sample);
        end else if (active_q) begin
            if (ss_rise) begin
                active_d = 1'b0;
                if (bit_cnt_q == 5'd16) begin
                    cmd_d  = shift_rx_q;
                    chan_d = new_chan;
                    rdy_d  = 1'b1;
                    if (advance) ptr_d = ptr_q + PTR_W'(1);
                end
            end else begin
                if (sclk_rise) begin
                    shift_rx_d = {shift_rx_q[14:0], mosi_sync_q[1]};
                    if (bit_cnt_q != 5'd16) bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (sclk_fall) shift_tx_d = {shift_tx_q[14:0], 1'b0};
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 1'b0;
            chan_q     <= '0;
            ptr_q      <= '0;
            shift_tx_q <= '0;
            shift_rx_q <= '0;
            bit_cnt_q  <= '0;
            cmd_q      <= '0;
            rdy_q      <= 1'b0;
        end else begin
            active_q   <= active_d;
            chan_q     <= chan_d;
            ptr_q      <= ptr_d;
            shift_tx_q <= shift_tx_d;
            shift_rx_q <= shift_rx_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_q      <= cmd_d;
            rdy_q      <= rdy_d;
        end
    end

    assign spi.MISO = active_q & ~rst & shift_tx_q[15];
    assign rdy      = rdy_q;
    assign cmd      = cmd_q;
    assign ptr      = ptr_q;

endmodule

// File: tb/tb_adc_spi_model.sv
// Directed bench for adc_spi_model: five instances with different parameter
// sets share one SPI bus; each test resets them all and checks one instance.
module tb_adc_spi_model;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic ss_n = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;

    always #5 clk = ~clk;

    adc_spi_model_if bus_a ();
    adc_spi_model_if bus_b ();
    adc_spi_model_if bus_c ();
    adc_spi_model_if bus_d ();
    adc_spi_model_if bus_e ();

    assign bus_a.SS_n = ss_n; assign bus_a.SCLK = sclk; assign bus_a.MOSI = mosi;
    assign bus_b.SS_n = ss_n; assign bus_b.SCLK = sclk; assign bus_b.MOSI = mosi;
    assign bus_c.SS_n = ss_n; assign bus_c.SCLK = sclk; assign bus_c.MOSI = mosi;
    assign bus_d.SS_n = ss_n; assign bus_d.SCLK = sclk; assign bus_d.MOSI = mosi;
    assign bus_e.SS_n = ss_n; assign bus_e.SCLK = sclk; assign bus_e.MOSI = mosi;

    logic        rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;
    logic [15:0] cmd_a, cmd_b, cmd_c, cmd_d, cmd_e;
    logic [12:0] ptr_a, ptr_b, ptr_c, ptr_e;
    logic [1:0]  ptr_d;

    adc_spi_model #(.ADV_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .spi(bus_a), .rdy(rdy_a), .cmd(cmd_a), .ptr(ptr_a));
    adc_spi_model #(.ADV_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .spi(bus_b), .rdy(rdy_b), .cmd(cmd_b), .ptr(ptr_b));
    adc_spi_model #(.ADV_MODE(2)) dut_c (
        .clk(clk), .rst(rst), .spi(bus_c), .rdy(rdy_c), .cmd(cmd_c), .ptr(ptr_c));
    adc_spi_model #(.DEPTH(4), .ADV_MODE(1)) dut_d (
        .clk(clk), .rst(rst), .spi(bus_d), .rdy(rdy_d), .cmd(cmd_d), .ptr(ptr_d));
    adc_spi_model #(.NUM_CH(16), .DATA_W(16), .ADV_MODE(0)) dut_e (
        .clk(clk), .rst(rst), .spi(bus_e), .rdy(rdy_e), .cmd(cmd_e), .ptr(ptr_e));

    int          errors = 0;
    int          checks = 0;
    int          rdy_cnt [5] = '{default: 0};
    logic [15:0] rx [5];
    logic        rdy_at2, rdy_at3;

    always @(negedge clk) begin
        if (rdy_a) rdy_cnt[0] <= rdy_cnt[0] + 1;
        if (rdy_b) rdy_cnt[1] <= rdy_cnt[1] + 1;
        if (rdy_c) rdy_cnt[2] <= rdy_cnt[2] + 1;
        if (rdy_d) rdy_cnt[3] <= rdy_cnt[3] + 1;
        if (rdy_e) rdy_cnt[4] <= rdy_cnt[4] + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        ss_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
    endtask

    task automatic sclk_pulse();
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
        wait_clk(4);
    endtask

    // Sends the low nbits of stream MSB first; MISO of every DUT is sampled
    // just before each SCLK rise, the last 16 bits kept in rx[].
    task automatic spi_frame(input logic [31:0] stream, input int nbits);
        for (int k = 0; k < 5; k++) rx[k] = '0;
        mosi = stream[nbits-1];
        ss_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            rx[0] = {rx[0][14:0], bus_a.MISO};
            rx[1] = {rx[1][14:0], bus_b.MISO};
            rx[2] = {rx[2][14:0], bus_c.MISO};
            rx[3] = {rx[3][14:0], bus_d.MISO};
            rx[4] = {rx[4][14:0], bus_e.MISO};
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
            mosi = (i + 1 < nbits) ? stream[nbits-2-i] : 1'b0;
            wait_clk(4);
        end
        ss_n = 1'b1;
        wait_clk(2);
        rdy_at2 = rdy_a;
        wait_clk(1);
        rdy_at3 = rdy_a;
        wait_clk(4);
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++; if (bus_a.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", bus_a.MISO); end
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", rdy_a); end
        checks++; if (cmd_a !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h expected 0000", cmd_a); end
        checks++; if (ptr_a !== 13'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", ptr_a); end
        repeat (3) sclk_pulse();
        n = rdy_cnt[0];
        spi_frame({16'h0, 16'h1800}, 16);
        checks++; if (rx[0] !== 16'h0000) begin errors++; $display("FAIL first_data: got %h expected 0000", rx[0]); end
        checks++; if (rdy_cnt[0] - n !== 1) begin errors++; $display("FAIL first_rdy_count: got %0d expected 1", rdy_cnt[0] - n); end
        checks++; if (rdy_at2 !== 1'b0) begin errors++; $display("FAIL rdy_early: got %b expected 0", rdy_at2); end
        checks++; if (rdy_at3 !== 1'b1) begin errors++; $display("FAIL rdy_latency: got %b expected 1", rdy_at3); end
        checks++; if (cmd_a !== 16'h1800) begin errors++; $display("FAIL first_cmd: got %h expected 1800", cmd_a); end
        checks++; if (ptr_a !== 13'd0) begin errors++; $display("FAIL mode0_ptr: got %0d expected 0", ptr_a); end
        spi_frame({16'h0, 16'h0000}, 16);
        checks++; if (rx[0] !== 16'h0003) begin errors++; $display("FAIL pipelined_data: got %h expected 0003", rx[0]); end
    endtask

    task automatic test_adv_every();
        logic [15:0] exp_rx [3];
        logic [12:0] exp_ptr [3];
        exp_rx  = '{16'h0000, 16'h000A, 16'h0012};
        exp_ptr = '{13'd1, 13'd2, 13'd3};
        do_reset();
        for (int f = 0; f < 3; f++) begin
            spi_frame({16'h0, 16'h1000}, 16);
            checks++; if (rx[1] !== exp_rx[f]) begin errors++; $display("FAIL adv1_data[%0d]: got %h expected %h", f, rx[1], exp_rx[f]); end
            checks++; if (ptr_b !== exp_ptr[f]) begin errors++; $display("FAIL adv1_ptr[%0d]: got %0d expected %0d", f, ptr_b, exp_ptr[f]); end
        end
    endtask

    task automatic test_adv_last();
        do_reset();
        spi_frame({16'h0, 16'h3800}, 16);
        checks++; if (ptr_c !== 13'd1) begin errors++; $display("FAIL adv2_ptr_ch7: got %0d expected 1", ptr_c); end
        spi_frame({16'h0, 16'h0000}, 16);
        checks++; if (rx[2] !== 16'h000F) begin errors++; $display("FAIL adv2_data_ch7: got %h expected 000f", rx[2]); end
        checks++; if (ptr_c !== 13'd1) begin errors++; $display("FAIL adv2_ptr_ch0: got %0d expected 1", ptr_c); end
        spi_frame({16'h0, 16'h0000}, 16);
        checks++; if (rx[2] !== 16'h0008) begin errors++; $display("FAIL adv2_data_ch0: got %h expected 0008", rx[2]); end
        checks++; if (ptr_c !== 13'd1) begin errors++; $display("FAIL adv2_ptr_hold: got %0d expected 1", ptr_c); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_ptr [5];
        exp_ptr = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int f = 0; f < 5; f++) begin
            spi_frame({16'h0, 16'h0000}, 16);
            checks++; if (ptr_d !== exp_ptr[f]) begin errors++; $display("FAIL wrap_ptr[%0d]: got %0d expected %0d", f, ptr_d, exp_ptr[f]); end
        end
    endtask

    task automatic test_abort();
        int n;
        do_reset();
        spi_frame({16'h0, 16'h1800}, 16);
        n = rdy_cnt[0];
        spi_frame({16'h0, 16'h3800}, 9);
        checks++; if (rdy_cnt[0] - n !== 0) begin errors++; $display("FAIL abort_rdy: got %0d pulses expected 0", rdy_cnt[0] - n); end
        checks++; if (cmd_a !== 16'h1800) begin errors++; $display("FAIL abort_cmd: got %h expected 1800", cmd_a); end
        checks++; if (ptr_a !== 13'd0) begin errors++; $display("FAIL abort_ptr: got %0d expected 0", ptr_a); end
        spi_frame({16'h0, 16'h0000}, 16);
        checks++; if (rx[0] !== 16'h0003) begin errors++; $display("FAIL abort_next_data: got %h expected 0003", rx[0]); end
    endtask

    task automatic test_long_frame();
        int n;
        do_reset();
        n = rdy_cnt[0];
        spi_frame(32'h0003_1000, 18);
        checks++; if (rdy_cnt[0] - n !== 1) begin errors++; $display("FAIL long_rdy: got %0d pulses expected 1", rdy_cnt[0] - n); end
        checks++; if (cmd_a !== 16'h1000) begin errors++; $display("FAIL long_cmd: got %h expected 1000", cmd_a); end
        spi_frame({16'h0, 16'h0000}, 16);
        checks++; if (rx[0] !== 16'h0002) begin errors++; $display("FAIL long_next_data: got %h expected 0002", rx[0]); end
    endtask

    task automatic test_wide_reset();
        int n;
        do_reset();
        spi_frame({16'h0, 16'h7800}, 16);
        checks++; if (cmd_e !== 16'h7800) begin errors++; $display("FAIL wide_cmd: got %h expected 7800", cmd_e); end
        spi_frame({16'h0, 16'h7800}, 16);
        checks++; if (rx[4] !== 16'h000F) begin errors++; $display("FAIL wide_data: got %h expected 000f", rx[4]); end
        mosi = 1'b1;
        ss_n = 1'b0;
        wait_clk(4);
        repeat (12) sclk_pulse();
        checks++; if (bus_e.MISO !== 1'b1) begin errors++; $display("FAIL wide_midframe_miso: got %b expected 1", bus_e.MISO); end
        rst = 1'b1;
        wait_clk(1);
        checks++; if (bus_e.MISO !== 1'b0) begin errors++; $display("FAIL rst_miso_in_reset: got %b expected 0", bus_e.MISO); end
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        checks++; if (bus_e.MISO !== 1'b0) begin errors++; $display("FAIL rst_miso_after: got %b expected 0", bus_e.MISO); end
        n = rdy_cnt[4];
        repeat (8) sclk_pulse();
        ss_n = 1'b1;
        mosi = 1'b0;
        wait_clk(6);
        checks++; if (rdy_cnt[4] - n !== 0) begin errors++; $display("FAIL rst_frame_rdy: got %0d pulses expected 0", rdy_cnt[4] - n); end
        checks++; if (cmd_e !== 16'h0000) begin errors++; $display("FAIL rst_cmd: got %h expected 0000", cmd_e); end
        checks++; if (ptr_e !== 13'd0) begin errors++; $display("FAIL rst_ptr: got %0d expected 0", ptr_e); end
        spi_frame({16'h0, 16'h0000}, 16);
        checks++; if (rx[4] !== 16'h0000) begin errors++; $display("FAIL rst_chan_data: got %h expected 0000", rx[4]); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_adv_every();
        test_adv_last();
        test_wrap();
        test_abort();
        test_long_frame();
        test_wide_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
